// File: rtl/align_pipe_multi.sv
// align_pipe_multi: two-stage exponent alignment pipeline.
// S1 captures the raw lanes together with the alignment exponent. That exponent is
// either the maximum lane exponent or an external override.
// S2 captures each lane shifted against that exponent, converted to two's complement,
// and flagged when the shift flushes the lane to zero.
// Each stage has valid/ready flow control. There is no skid buffer, so in_ready
// depends combinationally on out_ready.
module align_pipe_multi #(
    parameter int LANES = 4,
    parameter int MAN_W = 3,
    parameter int EXP_W = 6,
    parameter int OUT_W = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*(MAN_W+1)-1:0] in_pp,
    input  logic [LANES*EXP_W-1:0]     in_exp,
    input  logic                       ext_max_en,
    input  logic [EXP_W-1:0]           ext_max_exp,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*(OUT_W+1)-1:0] out_pp,
    output logic [EXP_W-1:0]           out_max_exp,
    output logic [LANES-1:0]           out_under
);

    localparam int PP_W = MAN_W + 1;
    localparam int OW1  = OUT_W + 1;
    localparam int SH   = OUT_W - MAN_W;

    logic                     s1_valid_q;
    logic [EXP_W-1:0]         s1_max_q, s1_max_d;
    logic [LANES*PP_W-1:0]    s1_pp_q;
    logic [LANES*EXP_W-1:0]   s1_exp_q;

    logic                     s2_valid_q;
    logic [EXP_W-1:0]         s2_max_q;
    logic [LANES*OW1-1:0]     s2_pp_q, s2_pp_d;
    logic [LANES-1:0]         s2_under_q, s2_under_d;

    logic                     s1_adv, s2_adv, in_fire;

    logic                     al_sign;
    logic [MAN_W-1:0]         al_mant;
    logic [EXP_W:0]           al_diff;
    logic [OUT_W-1:0]         al_mag;
    logic [OW1-1:0]           al_val;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_fire  = in_valid && in_ready;

    // Alignment exponent: unsigned maximum of all lanes, or the external override
    always_comb begin
        s1_max_d = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (in_exp[k*EXP_W +: EXP_W] > s1_max_d) begin
                s1_max_d = in_exp[k*EXP_W +: EXP_W];
            end
        end
        if (ext_max_en) begin
            s1_max_d = ext_max_exp;
        end
    end

    // Per-lane shift, flush to zero and sign application on S1 contents
    always_comb begin
        s2_pp_d    = '0;
        s2_under_d = '0;
        al_sign    = 1'b0;
        al_mant    = '0;
        al_diff    = '0;
        al_mag     = '0;
        al_val     = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            al_sign = s1_pp_q[k*PP_W + MAN_W];
            al_mant = s1_pp_q[k*PP_W +: MAN_W];
            // the extra top bit acts as a borrow: set only when the lane exponent exceeds the alignment exponent
            al_diff = {1'b0, s1_max_q} - {1'b0, s1_exp_q[k*EXP_W +: EXP_W]};
            if (al_diff[EXP_W]) begin
                al_diff = '0;
            end
            if (int'(al_diff) > SH) begin
                al_mag        = '0;
                s2_under_d[k] = 1'b1;
            end else begin
                al_mag = OUT_W'(al_mant) << (SH - int'(al_diff));
            end
            al_val = {1'b0, al_mag};
            if (al_sign) begin
                al_val = ~al_val + OW1'(1);
            end
            s2_pp_d[k*OW1 +: OW1] = al_val;
        end
    end

    // S1 register: load on accept; the valid bit refreshes whenever the stage advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_max_q   <= '0;
            s1_pp_q    <= '0;
            s1_exp_q   <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_fire;
            if (in_fire) begin
                s1_max_q <= s1_max_d;
                s1_pp_q  <= in_pp;
                s1_exp_q <= in_exp;
            end
        end
    end

    // S2 register: output stage, held while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_max_q   <= '0;
            s2_pp_q    <= '0;
            s2_under_q <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_max_q   <= s1_max_q;
                s2_pp_q    <= s2_pp_d;
                s2_under_q <= s2_under_d;
            end
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_pp      = s2_pp_q;
    assign out_max_exp = s2_max_q;
    assign out_under   = s2_under_q;

endmodule

// File: tb/tb_align_pipe_multi.sv
// tb_align_pipe_multi: directed-vector bench for align_pipe_multi at default parameters.
module tb_align_pipe_multi;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_pp;
    logic [23:0] in_exp;
    logic        ext_max_en;
    logic [5:0]  ext_max_exp;
    logic        out_valid;
    logic        out_ready;
    logic [59:0] out_pp;
    logic [5:0]  out_max_exp;
    logic [3:0]  out_under;

    align_pipe_multi #(
        .LANES(4),
        .MAN_W(3),
        .EXP_W(6),
        .OUT_W(14)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pp      (in_pp),
        .in_exp     (in_exp),
        .ext_max_en (ext_max_en),
        .ext_max_exp(ext_max_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pp     (out_pp),
        .out_max_exp(out_max_exp),
        .out_under  (out_under)
    );

    typedef struct {
        logic [15:0] pp;
        logic [23:0] ex;
        logic        een;
        logic [5:0]  eexp;
        logic [5:0]  mx;
        logic [59:0] opp;
        logic [3:0]  und;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs[NV];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic drive_vec(input int i);
        in_pp       = vecs[i].pp;
        in_exp      = vecs[i].ex;
        ext_max_en  = vecs[i].een;
        ext_max_exp = vecs[i].eexp;
    endtask

    task automatic check_out(input int i, input string pfx);
        chk($sformatf("%s_v%0d_max", pfx, i), 64'(out_max_exp), 64'(vecs[i].mx));
        chk($sformatf("%s_v%0d_under", pfx, i), 64'(out_under), 64'(vecs[i].und));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_v%0d_lane%0d", pfx, i, k), 64'(out_pp[k*15 +: 15]), 64'(vecs[i].opp[k*15 +: 15]));
        end
    endtask

    // Single transaction through an empty pipeline with out_ready held high
    task automatic run_one(input int i);
        out_ready = 1'b1;
        drive_vec(i);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk($sformatf("v%0d_lat1_valid", i), 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        chk($sformatf("v%0d_lat2_valid", i), 64'(out_valid), 64'(1));
        check_out(i, "one");
        @(posedge clk); #1;
        chk($sformatf("v%0d_drained", i), 64'(out_valid), 64'(0));
    endtask

    // Eight back-to-back transactions; each cycle checks in_ready against occupancy and the output against the queue head
    task automatic run_stream(input bit rnd, output int first_in, output int last_out);
        int  q[$];
        int  sent   = 0;
        int  got    = 0;
        int  occ    = 0;
        int  budget = 0;
        bit  fire_in, fire_out;
        first_in = 0;
        last_out = 0;
        while (got < 8 && budget < 200) begin
            budget++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < 8) begin
                drive_vec(sent % NV);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk("stream_in_ready", 64'(in_ready), 64'(!(occ == 2 && !out_ready)));
            if (q.size() == 0) begin
                chk("stream_spurious_valid", 64'(out_valid), 64'(0));
            end else if (out_valid) begin
                check_out(q[0], rnd ? "rnd" : "full");
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            @(posedge clk);
            cyc++;
            if (fire_in) begin
                q.push_back(sent % NV);
                if (sent == 0) first_in = cyc;
                sent++;
                occ++;
            end
            if (fire_out) begin
                if (q.size() > 0) void'(q.pop_front());
                got++;
                last_out = cyc;
                occ--;
            end
            #1;
        end
        in_valid = 1'b0;
        chk("stream_delivered", 64'(got), 64'(8));
    endtask

    initial begin
        int f, l;
        // v0: internal max 10, diffs 0/2/10
        vecs[0] = '{16'h33E5, {6'd0, 6'd0, 6'd8, 6'd10}, 1'b0, 6'd0, 6'd10,
                    {15'h0006, 15'h0006, 15'h7400, 15'h2800}, 4'b0000};
        // v1: diff 12 flushes a negative lane, diff 11 lands at bits [2:0]
        vecs[1] = '{{4'b1101, 4'b0111, 4'b1111, 4'b0001}, {6'd9, 6'd9, 6'd8, 6'd20}, 1'b0, 6'd0, 6'd20,
                    {15'h7FFB, 15'h0007, 15'h0000, 15'h0800}, 4'b0010};
        // v2: external exponent 5, lanes above it saturate to diff 0
        vecs[2] = '{{4'b0111, 4'b0101, 4'b0110, 4'b0100}, {6'd63, 6'd0, 6'd5, 6'd7}, 1'b1, 6'd5, 6'd5,
                    {15'h3800, 15'h0140, 15'h3000, 15'h2000}, 4'b0000};
        // v3: negative zero and negative full mantissa
        vecs[3] = '{{4'b1001, 4'b0000, 4'b1111, 4'b1000}, {6'd0, 6'd3, 6'd3, 6'd3}, 1'b0, 6'd0, 6'd3,
                    {15'h7F00, 15'h0000, 15'h4800, 15'h0000}, 4'b0000};
        // v4: exponents 0 and 63 together
        vecs[4] = '{{4'b1100, 4'b0010, 4'b0101, 4'b0111}, {6'd63, 6'd62, 6'd0, 6'd63}, 1'b0, 6'd0, 6'd63,
                    {15'h6000, 15'h0800, 15'h0000, 15'h3800}, 4'b0010};
        // v5: all exponents equal at 0
        vecs[5] = '{{4'b1011, 4'b0100, 4'b0010, 4'b0001}, 24'h0, 1'b0, 6'd0, 6'd0,
                    {15'h6800, 15'h2000, 15'h1000, 15'h0800}, 4'b0000};

        clk = 1'b0;
        rst = 1'b0;
        in_valid = 1'b0;
        in_pp = '0;
        in_exp = '0;
        ext_max_en = 1'b0;
        ext_max_exp = '0;
        out_ready = 1'b0;

        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_pp", 64'(out_pp), 64'(0));
        chk("rst_out_max", 64'(out_max_exp), 64'(0));
        chk("rst_out_under", 64'(out_under), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_release_in_ready", 64'(in_ready), 64'(1));

        for (int i = 0; i < NV; i++) run_one(i);

        run_stream(1'b1, f, l);
        run_stream(1'b0, f, l);
        chk("thru_span", 64'(l - f), 64'(9));

        // Fill both stages under backpressure, then reset between edges
        out_ready = 1'b0;
        drive_vec(0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive_vec(1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("full_out_valid", 64'(out_valid), 64'(1));
        chk("full_in_ready", 64'(in_ready), 64'(0));
        check_out(0, "held");
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_out_pp", 64'(out_pp), 64'(0));
        chk("midrst_out_max", 64'(out_max_exp), 64'(0));
        chk("midrst_out_under", 64'(out_under), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("midrst_stale_%0d", c), 64'(out_valid), 64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/align_pipe_multi.md
ALIGN_PIPE_MULTI -- requirements
Module: align_pipe_multi

Interface
REQ-001 SHALL have parameter LANES, default 4: number of partial products aligned per transaction.
REQ-002 SHALL have parameter MAN_W, default 3: unsigned mantissa width per lane, leading one included.
REQ-003 SHALL have parameter EXP_W, default 6: exponent width per lane.
REQ-004 SHALL have parameter OUT_W, default 14: aligned magnitude width, with OUT_W > MAN_W.
REQ-005 SHALL have port clk, input, 1: the single clock; all flops on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1: input transaction present.
REQ-008 SHALL have port in_ready, output, 1: block accepts input this cycle.
REQ-009 SHALL have port in_pp, input, LANES*(MAN_W+1): per lane, sign in the MSB and mantissa below it; lane k at bits [k*(MAN_W+1) +: MAN_W+1].
REQ-010 SHALL have port in_exp, input, LANES*EXP_W: unsigned exponent per lane, lane k at [k*EXP_W +: EXP_W].
REQ-011 SHALL have port ext_max_en, input, 1: when 1, use ext_max_exp instead of the internal maximum search.
REQ-012 SHALL have port ext_max_exp, input, EXP_W: external alignment exponent.
REQ-013 SHALL have port out_valid, output, 1: output transaction present.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts output.
REQ-015 SHALL have port out_pp, output, LANES*(OUT_W+1): two's-complement aligned value per lane, lane k at [k*(OUT_W+1) +: OUT_W+1].
REQ-016 SHALL have port out_max_exp, output, EXP_W: alignment exponent used for this transaction.
REQ-017 SHALL have port out_under, output, LANES: per lane, 1 when that lane's value was flushed to zero.

Function
REQ-018 SHALL be a 2-stage pipeline: S1 registers max_exp and the raw lanes; S2 registers the aligned and signed lanes; latency is 2 cycles with no stall.
REQ-019 SHALL, in S1, compute max_exp as the unsigned maximum of all LANES in_exp values when ext_max_en=0, and equal to ext_max_exp when ext_max_en=1.
REQ-020 SHALL compute diff = max_exp - exp_k per lane in EXP_W+1 bits; a negative diff (possible only in external mode) saturates to 0.
REQ-021 SHALL form mag_k = mantissa_k << (OUT_W-MAN_W-diff) when diff <= OUT_W-MAN_W; the bits shifted out below bit 0 are discarded.
REQ-022 SHALL set mag_k = 0 and out_under[k] = 1 when diff > OUT_W-MAN_W.
REQ-023 SHALL output out_pp lane = {1'b0, mag_k} when sign=0, and the (OUT_W+1)-bit two's complement of {1'b0, mag_k} when sign=1; a negative zero yields 0.
REQ-024 SHALL, for every stage, advance when the stage is empty or the next stage advances; S2 advances on out_ready, or when S2 is empty.
REQ-025 SHALL drive in_ready = !S1_valid | S1_advance; the combinational path runs from out_ready to in_ready, with no skid buffer.
REQ-026 SHALL accept a transaction only on in_valid & in_ready; data presented without in_ready is ignored.
REQ-027 SHALL hold out_pp, out_max_exp and out_under stable while out_valid=1 & out_ready=0.
REQ-028 SHALL sustain a throughput of 1 transaction/cycle when out_ready is held at 1.
REQ-029 SHALL, on a simultaneous accept and output in the same cycle, perform both operations with no bubble and no loss.
REQ-030 SHALL, when all lanes are equal, make every diff 0 and place every mantissa MSB-aligned in the OUT_W field.
REQ-031 SHALL treat exponent 0 and the maximum exponent 2^EXP_W-1 with no wrap in the maximum search or in diff.

Reset
REQ-032 SHALL, on rst=1, immediately clear S1_valid, S2_valid and out_valid to 0 and clear out_pp, out_max_exp and out_under to 0, asynchronously.
REQ-033 SHALL, on reset mid-operation, discard all in-flight transactions; the first cycle after rst deasserts has in_ready=1.

Verification
REQ-034 SHALL cover: defaults, ext_max_en=0; lane0 pp=4'b0101 exp=10; lane1 pp=4'b1110 exp=8; lanes2-3 pp=4'b0011 exp=0 -> after 2 cycles out_max_exp=10, lane0=15'h2800, lane1=15'h7400, lanes2-3=15'h0006, out_under=0.
REQ-035 SHALL cover: lane0 exp=20 and lane1 exp=8 (diff 12) -> lane1 out_pp=0, out_under[1]=1; a diff of exactly 11 gives mantissa at bits [2:0] and no flush.
REQ-036 SHALL cover: ext_max_en=1, ext_max_exp=5, lane exp=7, pp=4'b0100 -> diff saturates to 0, out_pp=15'h2000, out_max_exp=5.
REQ-037 SHALL cover: 8 back-to-back transactions with out_ready toggling randomly -> outputs in order and held during stalls; in_ready=0 only when both stages are full and out_ready=0; 8 transactions in 9 cycles when out_ready=1.
REQ-038 SHALL cover: rst asserted while both stages are full -> out_valid=0 in the same cycle with no clock edge, and no stale output after release.
REQ-039 SHALL cover: sign=1 with mantissa 0 -> out_pp=0; a negative lane with diff 0 and mantissa 3'b111 -> 15'h4800.
